// File: rtl/pearson_hash_engine.sv
// Sequential multi-lane Pearson hash: one message byte per clock against a
// runtime-loadable 256x8 table, digest returned through a valid/ready handshake.
module pearson_hash_engine #(
    parameter int MSG_BYTES  = 4,
    parameter int HASH_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*MSG_BYTES-1:0]  in_msg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*HASH_BYTES-1:0] out_hash,
    input  logic                    tbl_we,
    input  logic [7:0]              tbl_addr,
    input  logic [7:0]              tbl_wdata,
    output logic                    busy
);

    localparam int CNT_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [8*MSG_BYTES-1:0]         r_msg;
    logic [CNT_W-1:0]               r_cnt;
    logic [HASH_BYTES-1:0][7:0]     r_lane;
    logic [HASH_BYTES-1:0][7:0]     r_hash;
    logic [7:0]                     r_tbl [256];
    logic [HASH_BYTES-1:0][7:0]     w_idx;
    logic [HASH_BYTES-1:0][7:0]     w_lane_nxt;
    logic [7:0]                     w_byte;
    logic                           w_last;

    assign w_byte   = 8'(r_msg >> {r_cnt, 3'b000});
    assign w_last   = (r_cnt == LAST_CNT);
    assign out_hash = r_hash;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = HASH;
            end
            HASH: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // First byte seeds each lane with its own offset; later bytes chain through the lane value.
    always_comb begin
        w_idx      = '0;
        w_lane_nxt = '0;
        for (int i = 0; i < HASH_BYTES; i++) begin
            if (r_cnt == '0) w_idx[i] = w_byte + 8'(i);
            else             w_idx[i] = r_lane[i] ^ w_byte;
            w_lane_nxt[i] = r_tbl[w_idx[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_msg   <= '0;
            r_cnt   <= '0;
            r_lane  <= '0;
            r_hash  <= '0;
            for (int k = 0; k < 256; k++) r_tbl[k] <= 8'(k);
        end else begin
            r_state <= w_state_nxt;
            // Writes outside IDLE are dropped so one digest never sees two tables.
            if (tbl_we && (r_state == IDLE)) r_tbl[tbl_addr] <= tbl_wdata;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_msg  <= in_msg;
                        r_cnt  <= '0;
                        r_lane <= '0;
                    end
                end
                HASH: begin
                    r_lane <= w_lane_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) r_hash <= w_lane_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pearson_hash_engine.sv
// Directed bench for pearson_hash_engine (MSG_BYTES=4, HASH_BYTES=2) with
// hand-computed digests; lane 0 alone is the HASH_BYTES=1 result.
module tb_pearson_hash_engine;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_msg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_hash;
    logic        tbl_we;
    logic [7:0]  tbl_addr;
    logic [7:0]  tbl_wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [7:0] exp_lane [4];

    pearson_hash_engine #(.MSG_BYTES(4), .HASH_BYTES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] msg);
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        in_msg   = msg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        tick();
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_hash", {16'b0, out_hash}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;

        // identity table, two lanes
        out_ready = 1'b1;
        send(32'h04030201);
        check("t1_busy", {31'b0, busy}, 32'd1);
        wait_valid(lat);
        check("t1_latency", lat, 4);
        check("t1_hash", {16'b0, out_hash}, 32'h0704);
        check("t1_in_ready_done", {31'b0, in_ready}, 32'd0);
        tick();
        check("t1_idle_valid", {31'b0, out_valid}, 32'd0);
        check("t1_idle_ready", {31'b0, in_ready}, 32'd1);
        check("t1_hash_held", {16'b0, out_hash}, 32'h0704);

        // complemented table, lane-0 trajectory
        for (int k = 0; k < 256; k++) begin
            tbl_we    = 1'b1;
            tbl_addr  = 8'(k);
            tbl_wdata = ~8'(k);
            tick();
        end
        tbl_we = 1'b0;
        exp_lane[0] = 8'hFE;
        exp_lane[1] = 8'h03;
        exp_lane[2] = 8'hFF;
        exp_lane[3] = 8'h04;
        send(32'h04030201);
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("t2_lane0_step%0d", s), {24'b0, dut.r_lane[0]}, {24'b0, exp_lane[s]});
        end
        check("t2_valid", {31'b0, out_valid}, 32'd1);
        check("t2_hash", {16'b0, out_hash}, 32'h0704);
        tick();

        // reset restores identity; backpressure in DONE
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b0;
        send(32'h04030201);
        wait_valid(lat);
        check("t3_latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            check("t3_bp_valid", {31'b0, out_valid}, 32'd1);
            check("t3_bp_hash", {16'b0, out_hash}, 32'h0704);
            check("t3_bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        check("t3_bp_valid_end", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("t3_release_ready", {31'b0, in_ready}, 32'd1);
        check("t3_release_valid", {31'b0, out_valid}, 32'd0);

        // table write during HASH is dropped
        send(32'h04030201);
        tbl_we    = 1'b1;
        tbl_addr  = 8'h01;
        tbl_wdata = 8'hAA;
        tick();
        tbl_we = 1'b0;
        wait_valid(lat);
        check("t4_latency", lat, 3);
        check("t4_hash", {16'b0, out_hash}, 32'h0704);
        tick();
        send(32'h00000001);
        wait_valid(lat);
        check("t4_readback", {16'b0, out_hash}, 32'h0201);
        tick();

        // reset in the second HASH cycle abandons the message and the table
        tbl_we    = 1'b1;
        tbl_addr  = 8'h01;
        tbl_wdata = 8'hAA;
        tick();
        tbl_we = 1'b0;
        send(32'h04030201);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5_in_ready", {31'b0, in_ready}, 32'd1);
        check("t5_out_valid", {31'b0, out_valid}, 32'd0);
        check("t5_out_hash", {16'b0, out_hash}, 32'h0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        send(32'h00000001);
        wait_valid(lat);
        check("t5_latency", lat, 4);
        check("t5_hash", {16'b0, out_hash}, 32'h0201);
        tick();

        // simultaneous table write and accept in IDLE
        tbl_we    = 1'b1;
        tbl_addr  = 8'h01;
        tbl_wdata = 8'h55;
        send(32'h00000001);
        tbl_we = 1'b0;
        tick();
        check("t6_lane0_first", {24'b0, dut.r_lane[0]}, 32'h55);
        wait_valid(lat);
        check("t6_latency", lat, 3);
        check("t6_hash", {16'b0, out_hash}, 32'h0255);
        tick();
        check("t6_idle", {31'b0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pearson_hash_engine.md
Name: pearson_hash_engine

Overview:
Parametrised, sequential Pearson hash engine. It takes a MSG_BYTES-wide message through a valid/ready handshake and digests it one byte per clock against an internal, runtime-loadable 256x8 permutation table. It produces a HASH_BYTES x 8-bit digest, with one Pearson lane per output byte, presented through a valid/ready output handshake. It replaces the fixed 32-bit, 8-bit-digest hash in the coin datapath and is reused wherever a short keyed digest is needed.

Parameters:
MSG_BYTES, 4, message length in bytes (legal range 1..64).
HASH_BYTES, 1, digest length in bytes; one parallel lane per byte (legal range 1..8).

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  reset, synchronous, active-low
in_valid  input  1  message offered
in_ready  output  1  engine can accept a message
in_msg  input  8*MSG_BYTES  message; byte 0 = in_msg[7:0], processed first
out_valid  output  1  digest available
out_ready  input  1  consumer accepts digest
out_hash  output  8*HASH_BYTES  digest; lane i occupies bits [8i+7:8i]
tbl_we  input  1  table write strobe
tbl_addr  input  8  table write index
tbl_wdata  input  8  table write data
busy  output  1  high in HASH or DONE

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; in_ready=1; out_valid=0; out_hash=0; busy=0; byte counter=0; all lane registers=0; table T[k]=k for all k (identity). Reset mid-operation abandons the message; no digest is produced.
- FSM states: IDLE, HASH, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_msg, counter=0, lanes=0, go to HASH. in_ready depends on state only, never on in_valid.
- HASH: in_ready=0. Each cycle processes byte b=msg[8*cnt+7:8*cnt].
  - cnt==0: lane i <= T[(b + i) mod 256] (8-bit wrap on addition).
  - cnt>0: lane i <= T[lane_i XOR b].
  - cnt increments each cycle. On the cycle that processes cnt==MSG_BYTES-1, go to DONE and load out_hash from the final lane values in the same edge.
- DONE: out_valid=1 and out_hash held stable until out_valid&&out_ready, then go to IDLE with out_valid=0. out_hash keeps its last value after the handshake.
- Latency: out_valid rises exactly MSG_BYTES cycles after the accept edge. MSG_BYTES=1 goes HASH to DONE after one cycle.
- Throughput: at most one message per MSG_BYTES+2 cycles when out_ready is held high. No overlap of messages.
- Table port: tbl_we is honoured only in IDLE, writing T[tbl_addr]<=tbl_wdata at the edge.
  - tbl_we in HASH or DONE is silently dropped, so a digest always uses one consistent table.
  - tbl_we and in_valid in the same IDLE cycle: the write completes at that edge and the message is accepted at that edge. The message's first lookup therefore sees the new table entry.
- The table is not checked for being a permutation; non-permutation contents are legal and simply hashed.
- Index arithmetic is 8-bit only; no width growth.

Test Plan:
1. Reset, identity table, HASH_BYTES=2, MSG_BYTES=4, in_msg=32'h04030201, out_ready=1 -> out_valid 4 cycles after accept, out_hash=16'h0704 (lane0=04, lane1=07), then IDLE.
2. Load T[k]=~k for k=0..255 in IDLE, HASH_BYTES=1, in_msg=32'h04030201 -> out_hash=8'h04; intermediate lane0 values FE, 03, FF, 04.
3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_hash stable and in_ready=0 throughout; accept on out_ready=1, in_ready=1 the next cycle.
4. tbl_we T[01]=AA asserted while in HASH (identity table, in_msg=32'h04030201) -> write dropped, digest unchanged (8'h04); a later IDLE read-back via a fresh hash of 32'h00000001 (MSG_BYTES=4) gives 8'h01.
5. reset_n=0 on the 2nd HASH cycle -> next cycle in_ready=1, out_valid=0, out_hash=0, table back to identity; a following message hashes correctly.
6. Simultaneous tbl_we (T[01]=55) and in_valid in IDLE, in_msg=32'h00000001, HASH_BYTES=1 -> lane0 after byte0 = 55, final out_hash = T[55^00]... = 55 (identity elsewhere).
